lerp_pipe: RTL and testbench

//  Pipelined, channel-tagged linear interpolator: out = a + (b - a) * ratio.

---
 rtl/lerp_pipe_pkg.sv | 25 ++
 rtl/lerp_pipe_slice.sv | 49 ++++
 rtl/lerp_pipe.sv | 116 +++++++++++
 tb/tb_lerp_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lerp_pipe_pkg.sv
// Shared constants and a reference interpolator for lerp_pipe.
// The reference model is wide enough for any INPUT_BITS/RATIO_FRAC_BITS whose product fits in 64 bits.
package lerp_pipe_pkg;

  localparam int LERP_PIPE_LATENCY = 3;

  // Computes a + floor(((b - a) * ratio [+ half]) / 2^frac_bits) in wide integer arithmetic.
  function automatic logic [63:0] lerp_ref(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] ratio,
    input int unsigned frac_bits,
    input bit          round
  );
    logic signed [127:0] diff;
    logic signed [127:0] prod;
    logic signed [127:0] res;
    diff = $signed({64'd0, b}) - $signed({64'd0, a});
    prod = diff * $signed({64'd0, ratio});
    if (round && frac_bits > 0) prod = prod + (128'sd1 <<< (frac_bits - 1));
    res = $signed({64'd0, a}) + (prod >>> frac_bits);
    return res[63:0];
  endfunction

endpackage

// File: rtl/lerp_pipe_slice.sv
// One valid/ready register stage with bubble-collapsing stall.
// CLEAR_DATA also zeroes the payload on reset (used where the payload is visible at a port).
module lerp_pipe_slice #(
  parameter int WIDTH      = 8,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Loads when empty or when the held beat leaves this cycle.
  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) valid_d = valid_i;
    if (valid_i && ready_o) data_d = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  if (CLEAR_DATA) begin : g_clear
    always_ff @(posedge clk_i) begin
      if (reset_i) data_q <= '0;
      else         data_q <= data_d;
    end
  end else begin : g_hold
    always_ff @(posedge clk_i) begin
      data_q <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/lerp_pipe.sv
// Three-stage channel-tagged linear interpolator: out = a + (b - a) * ratio.
// Define LERP_PIPE_ROUND_EN to round half up instead of flooring the scaled difference.
module lerp_pipe
  import lerp_pipe_pkg::*;
#(
  parameter  int INPUT_BITS      = 16,
  parameter  int RATIO_FRAC_BITS = 8,
  parameter  int CHANNELS        = 4,
  localparam int CHAN_BITS       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHAN_BITS-1:0]       in_chan,
  input  logic [INPUT_BITS-1:0]      in_a,
  input  logic [INPUT_BITS-1:0]      in_b,
  input  logic [RATIO_FRAC_BITS-1:0] in_ratio,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHAN_BITS-1:0]       out_chan,
  output logic [INPUT_BITS-1:0]      out_data,
  output logic                       busy
);

  localparam int DIFF_W = INPUT_BITS + 1;
  localparam int PROD_W = INPUT_BITS + RATIO_FRAC_BITS + 1;
  localparam int S1_W   = CHAN_BITS + INPUT_BITS + RATIO_FRAC_BITS + DIFF_W;
  localparam int S2_W   = CHAN_BITS + INPUT_BITS + PROD_W;
  localparam int S3_W   = CHAN_BITS + INPUT_BITS;

  function automatic logic signed [DIFF_W-1:0] diff_of(
    input logic [INPUT_BITS-1:0] a,
    input logic [INPUT_BITS-1:0] b
  );
    return $signed({1'b0, b}) - $signed({1'b0, a});
  endfunction

  // Both operands are extended to the product width so no high bits are lost.
  function automatic logic signed [PROD_W-1:0] scale(
    input logic signed [DIFF_W-1:0]   d,
    input logic [RATIO_FRAC_BITS-1:0] r
  );
    logic signed [PROD_W-1:0] d_ext;
    logic signed [PROD_W-1:0] r_ext;
    d_ext = {{(PROD_W - DIFF_W){d[DIFF_W-1]}}, d};
    r_ext = {{(PROD_W - RATIO_FRAC_BITS){1'b0}}, r};
    return d_ext * r_ext;
  endfunction

  // The result is bounded by a and b, so dropping the upper bits never loses information.
  function automatic logic [INPUT_BITS-1:0] shift_add(
    input logic [INPUT_BITS-1:0] a,
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W-1:0] biased;
    logic signed [PROD_W-1:0] shifted;
    logic        [PROD_W-1:0] a_ext;
`ifdef LERP_PIPE_ROUND_EN
    biased = prod + (PROD_W'(1) <<< (RATIO_FRAC_BITS - 1));
`else
    biased = prod;
`endif
    shifted = biased >>> RATIO_FRAC_BITS;
    a_ext   = {{(PROD_W - INPUT_BITS){1'b0}}, a};
    return INPUT_BITS'(a_ext + shifted);
  endfunction

  logic                              s1_ready, s2_ready, s3_ready;
  logic                              s1_valid, s2_valid, s3_valid;
  logic [S1_W-1:0]                   s1_in, s1_data;
  logic [S2_W-1:0]                   s2_in, s2_data;
  logic [S3_W-1:0]                   s3_in, s3_data;
  logic [CHAN_BITS-1:0]              s1_chan, s2_chan;
  logic [INPUT_BITS-1:0]             s1_a, s2_a;
  logic [RATIO_FRAC_BITS-1:0]        s1_ratio;
  logic signed [DIFF_W-1:0]          s1_diff;
  logic signed [PROD_W-1:0]          s2_prod;

  // Stage 1: capture a, tag, ratio and the signed difference.
  assign s1_in = {in_chan, in_a, in_ratio, diff_of(in_a, in_b)};

  lerp_pipe_slice #(.WIDTH(S1_W), .CLEAR_DATA(1'b0)) u_s1 (
    .clk_i(clk), .reset_i(reset),
    .valid_i(in_valid), .ready_o(s1_ready), .data_i(s1_in),
    .valid_o(s1_valid), .ready_i(s2_ready), .data_o(s1_data)
  );

  assign {s1_chan, s1_a, s1_ratio, s1_diff} = s1_data;

  // Stage 2: the single shared multiply.
  assign s2_in = {s1_chan, s1_a, scale(s1_diff, s1_ratio)};

  lerp_pipe_slice #(.WIDTH(S2_W), .CLEAR_DATA(1'b0)) u_s2 (
    .clk_i(clk), .reset_i(reset),
    .valid_i(s1_valid), .ready_o(s2_ready), .data_i(s2_in),
    .valid_o(s2_valid), .ready_i(s3_ready), .data_o(s2_data)
  );

  assign {s2_chan, s2_a, s2_prod} = s2_data;

  // Stage 3: shift back to sample scale and add the start point.
  assign s3_in = {s2_chan, shift_add(s2_a, s2_prod)};

  lerp_pipe_slice #(.WIDTH(S3_W), .CLEAR_DATA(1'b1)) u_s3 (
    .clk_i(clk), .reset_i(reset),
    .valid_i(s2_valid), .ready_o(s3_ready), .data_i(s3_in),
    .valid_o(s3_valid), .ready_i(out_ready), .data_o(s3_data)
  );

  assign {out_chan, out_data} = s3_data;
  assign out_valid = s3_valid;
  assign in_ready  = s1_ready && !reset;
  assign busy      = s1_valid || s2_valid || s3_valid;

endmodule

// File: tb/tb_lerp_pipe.sv
// Scoreboard bench for lerp_pipe: a 16/8 instance for directed cases and a 24/37 instance for random beats.
// Honours LERP_PIPE_ROUND_EN when choosing expected values.
module tb_lerp_pipe;
  import lerp_pipe_pkg::*;

  localparam int NB = 16;
  localparam int NF = 8;
  localparam int WB = 24;
  localparam int WF = 37;
  localparam int NRAND = 10000;
`ifdef LERP_PIPE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]    in_chan, out_chan;
  logic [NB-1:0] in_a, in_b, out_data;
  logic [NF-1:0] in_ratio;

  logic          w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [1:0]    w_in_chan, w_out_chan;
  logic [WB-1:0] w_in_a, w_in_b, w_out_data;
  logic [WF-1:0] w_in_ratio;

  lerp_pipe #(.INPUT_BITS(NB), .RATIO_FRAC_BITS(NF), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
    .in_a(in_a), .in_b(in_b), .in_ratio(in_ratio),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_data(out_data), .busy(busy)
  );

  lerp_pipe #(.INPUT_BITS(WB), .RATIO_FRAC_BITS(WF), .CHANNELS(4)) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_chan(w_in_chan),
    .in_a(w_in_a), .in_b(w_in_b), .in_ratio(w_in_ratio),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_chan(w_out_chan),
    .out_data(w_out_data), .busy(w_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    exp_chan_q[$];
  logic [NB-1:0] exp_data_q[$];
  int            acc_cyc_q[$];
  logic [1:0]    w_chan_q[$];
  logic [WB-1:0] w_data_q[$];

  function automatic logic [NB-1:0] ref16(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input logic [NF-1:0] r);
    return NB'(lerp_ref(64'(a), 64'(b), 64'(r), NF, ROUND));
  endfunction

  function automatic logic [WB-1:0] ref24(input logic [WB-1:0] a, input logic [WB-1:0] b,
                                          input logic [WF-1:0] r);
    return WB'(lerp_ref(64'(a), 64'(b), 64'(r), WF, ROUND));
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; in_chan = '0; in_a = '0; in_b = '0; in_ratio = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_chan = '0; w_in_a = '0; w_in_b = '0; w_in_ratio = '0; w_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_chan !== '0)    begin errors++; $display("FAIL reset_out_chan: got %h want 0", out_chan); end
    checks++; if (w_out_valid !== 1'b0 || w_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_wide: got valid=%b ready=%b want 0/0", w_out_valid, w_in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    checks++; if (w_in_ready !== 1'b1) begin errors++; $display("FAIL release_w_in_ready: got %b want 1", w_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [NB-1:0] da [10] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF,
                                16'hFFFF, 16'hFFFF, 16'h1234, 16'h1000, 16'h2000};
    logic [NB-1:0] db [10] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                                16'h0000, 16'h0000, 16'h1234, 16'h2000, 16'h1000};
    logic [NF-1:0] dr [10] = '{8'h01, 8'h02, 8'h80, 8'h00, 8'h01, 8'h40, 8'h80, 8'hFF, 8'hFF, 8'hFF};
    logic [NB-1:0] et [10] = '{16'h00FF, 16'h01FF, 16'h7FFF, 16'hFFFF, 16'hFEFF,
                                16'hBFFF, 16'h7FFF, 16'h1234, 16'h1FF0, 16'h1010};
    logic [NB-1:0] er [10] = '{16'h0100, 16'h0200, 16'h8000, 16'hFFFF, 16'hFEFF,
                                16'hBFFF, 16'h8000, 16'h1234, 16'h1FF0, 16'h1010};
    int idx = 0, got = 0, t = 0, ac;
    logic [NB-1:0] ed;
    logic [1:0]    ec;
    out_ready = 1'b1;
    while ((idx < 10 || got < 10) && t < 60) begin
      if (idx < 10) begin
        in_valid = 1'b1; in_chan = 2'(idx); in_a = da[idx]; in_b = db[idx]; in_ratio = dr[idx];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++; $display("FAIL directed_extra: got %h want no output", out_data);
        end else begin
          ed = exp_data_q.pop_front(); ec = exp_chan_q.pop_front(); ac = acc_cyc_q.pop_front();
          if (out_data !== ed || out_chan !== ec) begin
            errors++; $display("FAIL directed_%0d: got %h/ch%0d want %h/ch%0d", got, out_data, out_chan, ed, ec);
          end
          if (got == 0) begin
            checks++;
            if (cyc - ac != LERP_PIPE_LATENCY) begin
              errors++; $display("FAIL directed_latency: got %0d want %0d", cyc - ac, LERP_PIPE_LATENCY);
            end
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_data_q.push_back(ROUND ? er[idx] : et[idx]);
        exp_chan_q.push_back(2'(idx));
        acc_cyc_q.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    checks++; if (got != 10) begin errors++; $display("FAIL directed_count: got %0d want 10", got); end
  endtask

  task automatic test_back_to_back();
    int idx = 0, got = 0, t = 0, prev = -1;
    logic [NB-1:0] ed;
    logic [1:0]    ec;
    out_ready = 1'b1;
    while ((idx < 4 || got < 4) && t < 30) begin
      if (idx < 4) begin
        in_valid = 1'b1; in_chan = 2'(idx);
        if (in_a == '0 || idx == 0 || !in_ready) ;
        in_a = NB'($urandom); in_b = NB'($urandom); in_ratio = NF'($urandom);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        ed = exp_data_q.pop_front(); ec = exp_chan_q.pop_front(); void'(acc_cyc_q.pop_front());
        checks++;
        if (out_data !== ed || out_chan !== ec) begin
          errors++; $display("FAIL b2b_%0d: got %h/ch%0d want %h/ch%0d", got, out_data, out_chan, ed, ec);
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != 1) begin errors++; $display("FAIL b2b_gap_%0d: got %0d want 1", got, cyc - prev); end
        end
        prev = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_data_q.push_back(ref16(in_a, in_b, in_ratio));
        exp_chan_q.push_back(in_chan);
        acc_cyc_q.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
  endtask

  task automatic test_stall();
    logic [NB-1:0] sa [10], sb [10];
    logic [NF-1:0] sr [10];
    int idx = 0, got = 0, t = 0;
    logic prev_stall = 1'b0;
    logic [NB-1:0] prev_data, ed;
    logic [1:0]    prev_chan, ec;
    for (int i = 0; i < 10; i++) begin
      sa[i] = NB'($urandom); sb[i] = NB'($urandom); sr[i] = NF'($urandom);
    end
    while ((idx < 10 || got < 10) && t < 60) begin
      out_ready = (t >= 5);
      if (idx < 10) begin
        in_valid = 1'b1; in_chan = 2'(idx + 1); in_a = sa[idx]; in_b = sb[idx]; in_ratio = sr[idx];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (t == 4) begin
        checks++;
        if (idx != 3 || in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_fill: got %0d buffered ready=%b want 3 ready=0", idx, in_ready);
        end
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_chan !== prev_chan) begin
          errors++; $display("FAIL stall_hold: got %b %h/ch%0d want 1 %h/ch%0d",
                             out_valid, out_data, out_chan, prev_data, prev_chan);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_chan  = out_chan;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++; $display("FAIL stall_extra: got %h want no output", out_data);
        end else begin
          ed = exp_data_q.pop_front(); ec = exp_chan_q.pop_front(); void'(acc_cyc_q.pop_front());
          if (out_data !== ed || out_chan !== ec) begin
            errors++; $display("FAIL stall_%0d: got %h/ch%0d want %h/ch%0d", got, out_data, out_chan, ed, ec);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_data_q.push_back(ref16(in_a, in_b, in_ratio));
        exp_chan_q.push_back(in_chan);
        acc_cyc_q.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 10 || exp_data_q.size() != 0) begin
      errors++; $display("FAIL stall_count: got %0d left %0d want 10 left 0", got, exp_data_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int ac = 0, outs = 0;
    logic [NB-1:0] ed;
    out_ready = 1'b1;
    in_valid = 1'b1; in_chan = 2'd1; in_a = 16'h1111; in_b = 16'h9999; in_ratio = 8'h33;
    @(negedge clk);
    @(posedge clk); #1;
    in_chan = 2'd2; in_a = 16'h2222; in_b = 16'h0101; in_ratio = 8'hC0;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL midreset_during: got ready=%b busy=%b want 0/1", in_ready, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_after: got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    exp_data_q.delete(); exp_chan_q.delete(); acc_cyc_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1; in_chan = 2'd3; in_a = 16'h4000; in_b = 16'hC000; in_ratio = 8'h20;
    ed = ref16(16'h4000, 16'hC000, 8'h20);
    @(negedge clk);
    ac = cyc;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_accept: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        outs++;
        checks++;
        if (cyc - ac != LERP_PIPE_LATENCY || out_data !== ed || out_chan !== 2'd3) begin
          errors++; $display("FAIL midreset_beat: got lat %0d %h/ch%0d want lat %0d %h/ch3",
                             cyc - ac, out_data, out_chan, LERP_PIPE_LATENCY, ed);
        end
      end
    end
    checks++; if (outs != 1) begin errors++; $display("FAIL midreset_count: got %0d want 1", outs); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_wide();
    int sent = 0, got = 0, t = 0, sel;
    logic pending = 1'b0;
    logic [WB-1:0] ed;
    logic [1:0]    ec;
    while ((sent < NRAND || got < NRAND) && t < 40000) begin
      if (!pending) begin
        if (sent < NRAND && $urandom_range(0, 4) != 0) begin
          pending = 1'b1;
          w_in_valid = 1'b1;
          w_in_chan  = 2'($urandom);
          w_in_a     = WB'($urandom);
          w_in_b     = WB'($urandom);
          w_in_ratio = WF'({$urandom, $urandom});
          sel = $urandom_range(0, 9);
          if (sel == 0) w_in_ratio = '0;
          if (sel == 1) w_in_ratio = '1;
          if (sel == 2) w_in_b = w_in_a;
        end else w_in_valid = 1'b0;
      end
      w_out_ready = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      if (w_out_valid && w_out_ready) begin
        checks++;
        if (w_data_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got %h want no output", w_out_data);
        end else begin
          ed = w_data_q.pop_front(); ec = w_chan_q.pop_front();
          if (w_out_data !== ed || w_out_chan !== ec) begin
            errors++; $display("FAIL rand_%0d: got %h/ch%0d want %h/ch%0d", got, w_out_data, w_out_chan, ed, ec);
          end
        end
        got++;
      end
      if (w_in_valid && w_in_ready) begin
        w_data_q.push_back(ref24(w_in_a, w_in_b, w_in_ratio));
        w_chan_q.push_back(w_in_chan);
        sent++;
        pending = 1'b0;
      end
      @(posedge clk); #1;
      if (!pending) w_in_valid = 1'b0;
      t++;
    end
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    checks++;
    if (got != NRAND || w_data_q.size() != 0) begin
      errors++; $display("FAIL rand_count: got %0d left %0d want %0d left 0", got, w_data_q.size(), NRAND);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
